// File: rtl/rv32_pkg.sv
// Shared RV32 opcode/funct3 constants and the memory-access stage state type.
// Misalignment helper is used only when MA_MISALIGN_TRAP_EN is defined.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    WAIT
  } ma_state_t;

  // Unknown load funct3 decodes as a word, so it gets the word alignment rule.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo,
                                         input logic is_load);
    logic r_mis;
    r_mis = 1'b0;
    if (funct3 == F3_B || (is_load && funct3 == F3_BU)) begin
      r_mis = 1'b0;
    end else if (funct3 == F3_H || (is_load && funct3 == F3_HU)) begin
      r_mis = addr_lo[0];
    end else begin
      r_mis = (addr_lo != 2'b00);
    end
    return r_mis;
  endfunction

endpackage

// File: rtl/ma_load_align.sv
// Combinational load-data lane select and sign/zero extension.
module ma_load_align
  import rv32_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_addr_lo)
      2'b00: w_byte = i_rdata[7:0];
      2'b01: w_byte = i_rdata[15:8];
      2'b10: w_byte = i_rdata[23:16];
      2'b11: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_data = {24'h0, w_byte};
      F3_HU:   o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: issues dmem req/ack transactions and registers MA/WB results.
// Optional MA_MISALIGN_TRAP_EN retires misaligned accesses in one cycle with exc_Wb set.
module ma_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_Ma,
  input  logic [XLEN-1:0] pc_Ma,
  input  logic [XLEN-1:0] alu_out_Ma,
  input  logic [XLEN-1:0] rs2_Ma,
  input  logic [31:0]     inst_Ma,
  output logic            stall_Ma,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            valid_Wb,
  output logic [XLEN-1:0] pc_Wb,
  output logic [XLEN-1:0] alu_out_Wb,
  output logic [XLEN-1:0] mem_data_Wb,
  output logic [31:0]     inst_Wb,
  output logic            exc_Wb
);

  ma_state_t r_state, w_state_d;

  logic [XLEN-1:0] r_req_pc, r_req_alu, r_req_wdata;
  logic [31:0]     r_req_inst;
  logic [3:0]      r_req_be;
  logic            r_req_we;

  logic            r_valid_wb;
  logic [XLEN-1:0] r_pc_wb, r_alu_wb, r_mem_wb;
  logic [31:0]     r_inst_wb;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_is_load, w_is_store, w_is_mem, w_misalign;
  logic            w_wait, w_issue, w_retire_now, w_ack_done;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata, w_load_data;

  assign w_opcode   = inst_Ma[6:0];
  assign w_funct3   = inst_Ma[14:12];
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;

`ifdef MA_MISALIGN_TRAP_EN
  assign w_misalign = w_is_mem & is_misaligned(w_funct3, alu_out_Ma[1:0], w_is_load);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_wait       = (r_state == WAIT);
  assign w_issue      = (r_state == IDLE) & valid_Ma & w_is_mem & ~w_misalign;
  assign w_retire_now = (r_state == IDLE) & valid_Ma & (~w_is_mem | w_misalign);
  assign w_ack_done   = w_wait & dmem_ack;

  // Loads carry no byte enables; only stores fill lanes.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = rs2_Ma;
    if (w_is_store) begin
      case (w_funct3)
        F3_B: begin
          w_be    = 4'b0001 << alu_out_Ma[1:0];
          w_wdata = {4{rs2_Ma[7:0]}};
        end
        F3_H: begin
          w_be    = 4'b0011 << {alu_out_Ma[1], 1'b0};
          w_wdata = {2{rs2_Ma[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = rs2_Ma;
        end
      endcase
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_issue) w_state_d = WAIT;
      WAIT:    if (dmem_ack) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_pc    <= '0;
      r_req_alu   <= '0;
      r_req_wdata <= '0;
      r_req_inst  <= '0;
      r_req_be    <= '0;
      r_req_we    <= 1'b0;
    end else if (w_issue) begin
      r_req_pc    <= pc_Ma;
      r_req_alu   <= alu_out_Ma;
      r_req_wdata <= w_wdata;
      r_req_inst  <= inst_Ma;
      r_req_be    <= w_be;
      r_req_we    <= w_is_store;
    end
  end

  ma_load_align u_load_align (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (r_req_alu[1:0]),
    .i_funct3  (r_req_inst[14:12]),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_wb <= 1'b0;
      r_pc_wb    <= '0;
      r_alu_wb   <= '0;
      r_mem_wb   <= '0;
      r_inst_wb  <= '0;
    end else begin
      r_valid_wb <= w_retire_now | w_ack_done;
      if (w_retire_now) begin
        r_pc_wb   <= pc_Ma;
        r_alu_wb  <= alu_out_Ma;
        r_mem_wb  <= '0;
        r_inst_wb <= inst_Ma;
      end else if (w_ack_done) begin
        r_pc_wb   <= r_req_pc;
        r_alu_wb  <= r_req_alu;
        r_mem_wb  <= r_req_we ? '0 : w_load_data;
        r_inst_wb <= r_req_inst;
      end
    end
  end

`ifdef MA_MISALIGN_TRAP_EN
  logic r_exc_wb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exc_wb <= 1'b0;
    end else if (w_retire_now) begin
      r_exc_wb <= w_misalign;
    end else if (w_ack_done) begin
      r_exc_wb <= 1'b0;
    end
  end

  assign exc_Wb = r_exc_wb;
`else
  assign exc_Wb = 1'b0;
`endif

  // Request signals decode from state so an async reset drops them immediately.
  assign stall_Ma   = w_wait;
  assign dmem_req   = w_wait;
  assign dmem_we    = w_wait & r_req_we;
  assign dmem_addr  = w_wait ? {r_req_alu[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata = w_wait ? r_req_wdata : '0;
  assign dmem_be    = w_wait ? r_req_be : 4'b0000;

  assign valid_Wb    = r_valid_wb;
  assign pc_Wb       = r_pc_wb;
  assign alu_out_Wb  = r_alu_wb;
  assign mem_data_Wb = r_mem_wb;
  assign inst_Wb     = r_inst_wb;

endmodule

// File: tb/tb_ma_stage.sv
// Scoreboard bench for ma_stage: randomized loads/stores/ALU ops against an arithmetic model.
module tb_ma_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_Ma;
  logic [31:0] pc_Ma, alu_out_Ma, rs2_Ma, inst_Ma;
  logic        stall_Ma, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        valid_Wb, exc_Wb;
  logic [31:0] pc_Wb, alu_out_Wb, mem_data_Wb, inst_Wb;

  always #5 clk = ~clk;

  ma_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_Ma    (valid_Ma),
    .pc_Ma       (pc_Ma),
    .alu_out_Ma  (alu_out_Ma),
    .rs2_Ma      (rs2_Ma),
    .inst_Ma     (inst_Ma),
    .stall_Ma    (stall_Ma),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_be     (dmem_be),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .valid_Wb    (valid_Wb),
    .pc_Wb       (pc_Wb),
    .alu_out_Wb  (alu_out_Wb),
    .mem_data_Wb (mem_data_Wb),
    .inst_Wb     (inst_Wb),
    .exc_Wb      (exc_Wb)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic        we;
    int          delay;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] inst;
    logic [31:0] mem;
    logic        exc;
  } wb_t;

  req_t req_q[$];
  wb_t  wb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   resp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext8(input logic [31:0] b);
    return (b & 32'h80) != 0 ? (b | 32'hffffff00) : b;
  endfunction

  function automatic logic [31:0] sext16(input logic [31:0] h);
    return (h & 32'h8000) != 0 ? (h | 32'hffff0000) : h;
  endfunction

  // Reference: what memory should see and what WB should present, from the ISA rules.
  task automatic model(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] rdata, input int delay);
    logic [31:0] op, f3, a, bval, hval, ext;
    bit          is_ld, is_st, mis;
    req_t        r;
    wb_t         w;
    op    = inst & 32'h7f;
    f3    = (inst >> 12) & 32'h7;
    a     = addr % 4;
    is_ld = (op == 32'h03);
    is_st = (op == 32'h23);
    mis   = 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
    if (is_ld || is_st) begin
      if (f3 == 0 || (is_ld && f3 == 4)) mis = 1'b0;
      else if (f3 == 1 || (is_ld && f3 == 5)) mis = (a % 2) != 0;
      else mis = (a != 0);
    end
`endif
    w.pc = pc; w.alu = addr; w.inst = inst; w.mem = 32'h0; w.exc = mis;
    if ((is_ld || is_st) && !mis) begin
      r.addr  = addr - a;
      r.we    = is_st;
      r.rdata = rdata;
      r.delay = delay;
      r.be    = 4'h0;
      r.wdata = rs2;
      if (is_st) begin
        if (f3 == 0) begin
          r.be = 4'(1 << a); r.wdata = (rs2 & 32'hff) * 32'h01010101;
        end else if (f3 == 1) begin
          r.be = 4'(3 << (2 * (a / 2))); r.wdata = (rs2 & 32'hffff) * 32'h00010001;
        end else begin
          r.be = 4'hf;
        end
      end else begin
        bval = (rdata >> (8 * a)) & 32'hff;
        hval = (rdata >> (16 * (a / 2))) & 32'hffff;
        case (f3)
          0:       ext = sext8(bval);
          1:       ext = sext16(hval);
          4:       ext = bval;
          5:       ext = hval;
          default: ext = rdata;
        endcase
        w.mem = ext;
      end
      req_q.push_back(r);
    end
    wb_q.push_back(w);
  endtask

  task automatic garbage(input bit stalled);
    valid_Ma   = stalled ? 1'($urandom_range(0, 1)) : 1'b0;
    pc_Ma      = $urandom;
    alu_out_Ma = $urandom;
    rs2_Ma     = $urandom;
    inst_Ma    = $urandom;
  endtask

  // Called at a negedge; returns at the negedge after the instruction is sampled.
  task automatic issue(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] rdata, input int delay);
    int          guard;
    logic [31:0] pc;
    guard = 0;
    while (stall_Ma && guard < 100) begin
      garbage(1'b1);
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("stall_timeout", 32'(stall_Ma), 32'h0);
    pc         = $urandom;
    valid_Ma   = 1'b1;
    pc_Ma      = pc;
    alu_out_Ma = addr;
    rs2_Ma     = rs2;
    inst_Ma    = inst;
    model(inst, addr, rs2, pc, rdata, delay);
    @(negedge clk);
    garbage(stall_Ma);
  endtask

  task automatic bubble();
    garbage(stall_Ma);
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_inst(input logic [31:0] op, input logic [31:0] f3);
    logic [31:0] v;
    v = $urandom;
    return (v & 32'hffff8f80) | (f3 << 12) | op;
  endfunction

  // Memory responder: checks each request and acks after the scheduled number of cycles.
  initial begin
    req_t r;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!resp_en) continue;
      if (!dmem_req) begin
        dmem_ack   = ($urandom_range(0, 7) == 0);
        dmem_rdata = $urandom;
        continue;
      end
      if (req_q.size() == 0) begin
        chk("unexpected_dmem_req", 32'(dmem_req), 32'h0);
        r.addr = dmem_addr; r.we = dmem_we; r.be = dmem_be; r.wdata = dmem_wdata;
        r.rdata = 32'h0; r.delay = 0;
      end else begin
        r = req_q.pop_front();
        chk("dmem_addr", dmem_addr, r.addr);
        chk("dmem_we", 32'(dmem_we), 32'(r.we));
        chk("dmem_be", 32'(dmem_be), 32'(r.be));
        if (r.we) chk("dmem_wdata", dmem_wdata, r.wdata);
      end
      chk("stall_first_wait", 32'(stall_Ma), 32'h1);
      for (int k = 0; k < r.delay; k++) begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        @(negedge clk);
        chk("stall_in_wait", 32'(stall_Ma), 32'h1);
        chk("addr_stable", dmem_addr, r.addr);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = r.rdata;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("req_drop_after_ack", 32'(dmem_req), 32'h0);
      chk("stall_drop_after_ack", 32'(stall_Ma), 32'h0);
    end
  end

  // WB monitor: every presented result must match the oldest expected retirement.
  initial begin
    wb_t w;
    forever begin
      @(negedge clk);
      if (rst_n && valid_Wb) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_valid_Wb", 32'(valid_Wb), 32'h0);
        end else begin
          w = wb_q.pop_front();
          chk("pc_Wb", pc_Wb, w.pc);
          chk("alu_out_Wb", alu_out_Wb, w.alu);
          chk("inst_Wb", inst_Wb, w.inst);
          chk("mem_data_Wb", mem_data_Wb, w.mem);
          chk("exc_Wb", 32'(exc_Wb), 32'(w.exc));
        end
      end
    end
  end

  initial begin
    int          guard;
    int          sel;
    logic [31:0] f3;
    rst_n = 1'b0;
    valid_Ma = 1'b0; pc_Ma = 32'h0; alu_out_Ma = 32'h0; rs2_Ma = 32'h0; inst_Ma = 32'h0;
    #3;
    chk("rst_valid_Wb", 32'(valid_Wb), 32'h0);
    chk("rst_stall", 32'(stall_Ma), 32'h0);
    chk("rst_dmem_req", 32'(dmem_req), 32'h0);
    chk("rst_pc_Wb", pc_Wb, 32'h0);
    chk("rst_mem_data_Wb", mem_data_Wb, 32'h0);
    chk("rst_exc_Wb", 32'(exc_Wb), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    resp_en = 1'b1;
    @(negedge clk);

    // Directed cases first, then randomized traffic.
    issue(mk_inst(32'h33, 0), 32'h0000_0011, $urandom, 32'h0, 0);
    issue(mk_inst(32'h23, 0), 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 2);
    issue(mk_inst(32'h03, 0), 32'h0000_2002, 32'h0, 32'h0080_0000, 0);
    issue(mk_inst(32'h03, 4), 32'h0000_2002, 32'h0, 32'h0080_0000, 1);
    issue(mk_inst(32'h03, 5), 32'h0000_2002, 32'h0, 32'h8001_0000, 0);
    issue(mk_inst(32'h03, 2), 32'h0000_3001, 32'h0, 32'h1234_5678, 0);
    issue(mk_inst(32'h03, 2), 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 0);
    issue(mk_inst(32'h03, 1), 32'h0000_4006, 32'h0, 32'h8765_4321, 0);
    issue(mk_inst(32'h23, 1), 32'h0000_5003, 32'h1234_ABCD, 32'h0, 0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        bubble();
      end else if (sel <= 4) begin
        issue(mk_inst(32'h03, $urandom_range(0, 7)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3));
      end else if (sel <= 7) begin
        f3 = $urandom_range(0, 2);
        issue(mk_inst(32'h23, f3), $urandom, $urandom, $urandom, $urandom_range(0, 3));
      end else begin
        issue($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 3));
      end
    end

    guard = 0;
    while ((wb_q.size() != 0 || req_q.size() != 0 || stall_Ma) && guard < 200) begin
      garbage(stall_Ma);
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("drain_timeout", 32'(wb_q.size() + req_q.size()), 32'h0);
    valid_Ma = 1'b0;
    @(negedge clk);

    // Reset while a load is outstanding; a late ack must not retire anything.
    resp_en    = 1'b0;
    dmem_ack   = 1'b0;
    valid_Ma   = 1'b1;
    inst_Ma    = 32'h0000_2003;
    alu_out_Ma = 32'h0000_4000;
    @(negedge clk);
    valid_Ma = 1'b0;
    chk("wait_req_before_rst", 32'(dmem_req), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(dmem_req), 32'h0);
    chk("rst_mid_stall", 32'(stall_Ma), 32'h0);
    chk("rst_mid_addr", dmem_addr, 32'h0);
    chk("rst_mid_be", 32'(dmem_be), 32'h0);
    chk("rst_mid_valid_Wb", 32'(valid_Wb), 32'h0);
    chk("rst_mid_alu_out_Wb", alu_out_Wb, 32'h0);
    chk("rst_mid_inst_Wb", inst_Wb, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("late_ack_valid_Wb", 32'(valid_Wb), 32'h0);
      chk("late_ack_req", 32'(dmem_req), 32'h0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
Name: ma_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes pc_Ma, alu_out_Ma, rs2_Ma and inst_Ma.
- Issues load/store transactions to data memory over a req/ack handshake, and byte/half-aligns and sign- or zero-extends load data.
- Registers results into the MA/WB pipeline boundary, stalling upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- valid_Ma  in  1  instruction on *_Ma inputs is valid
- pc_Ma  in  32  PC from EX
- alu_out_Ma  in  32  ALU result; effective address for load/store
- rs2_Ma  in  32  store data
- inst_Ma  in  32  instruction word
- stall_Ma  out  1  back-pressure to EX and earlier stages; upstream holds inputs while high
- dmem_req  out  1  memory request
- dmem_we  out  1  1=store, 0=load
- dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables (stores only; 0 for loads)
- dmem_ack  in  1  memory completion; rdata valid the same cycle
- dmem_rdata  in  32  load data word
- valid_Wb  out  1  WB-stage instruction valid
- pc_Wb  out  32  registered PC
- alu_out_Wb  out  32  registered ALU result
- mem_data_Wb  out  32  extended load data; 0 for non-loads
- inst_Wb  out  32  registered instruction
- exc_Wb  out  1  misaligned-access flag (see Optional Feature)

Behaviour:
- Reset: all outputs 0; state=IDLE; internal request registers cleared.
- Classification uses inst_Ma[6:0]: LOAD=0000011, STORE=0100011, everything else is non-memory.
- FSM has two states, IDLE and WAIT.
- IDLE, valid_Ma and non-memory:
  - WB registers load the inputs on the next edge; valid_Wb=1.
  - mem_data_Wb=0.
  - Latency 1 cycle.
- IDLE, valid_Ma and load/store:
  - Capture addr, data, be, we and the instruction fields into request registers.
  - Go to WAIT.
  - valid_Wb=0 on the next cycle (bubble).
- IDLE, !valid_Ma: valid_Wb=0; other WB registers hold.
- WAIT:
  - dmem_req=1.
  - dmem_addr/we/wdata/be are stable, driven from the request registers.
  - stall_Ma=1 (decoded from state).
  - Stay in WAIT until dmem_ack=1 is sampled.
- Ack edge:
  - WB registers load the captured fields; valid_Wb=1.
  - mem_data_Wb = extended rdata for loads, 0 for stores.
  - Return to IDLE; dmem_req and stall_Ma drop the following cycle.
  - Ack at the N-th WAIT cycle gives valid_Wb at cycle N+1 after capture.
- dmem_ack while in IDLE is ignored.
- Upstream inputs presented while stall_Ma=1 are not sampled.
- Store lanes, by funct3 = inst[14:12]:
  - SB: be=4'b0001<<a[1:0]; wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<{a[1],1'b0}; wdata={2{rs2[15:0]}}.
  - SW: be=4'b1111; wdata=rs2.
- Load extraction: select byte a[1:0] or half a[1] from rdata.
  - LB (000): sign-extend byte.
  - LH (001): sign-extend half.
  - LW (010): full word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
  - Any other funct3 is treated as LW.
- Reset asserted mid-WAIT:
  - dmem_req drops immediately (async).
  - State goes to IDLE.
  - A late ack arriving after reset is ignored.

Optional Feature:
- Macro: MA_MISALIGN_TRAP_EN.
- Defined:
  - LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0, issues no dmem_req.
  - Stays in IDLE; the instruction retires in 1 cycle with exc_Wb=1 and mem_data_Wb=0.
- Undefined:
  - exc_Wb is tied 0.
  - Misaligned low address bits are ignored: half uses lane a[1]; word ignores a[1:0].

Decomposition:
- Package rv32_pkg holds:
  - OP_LOAD and OP_STORE opcode constants.
  - F3_B, F3_H, F3_W, F3_BU, F3_HU funct3 constants.
  - ma_state_t enum {IDLE, WAIT}.
- Sub-module ma_load_align: combinational rdata + a[1:0] + funct3 -> 32-bit extended data. It is reused by any future cache path.

Test Plan:
- ADD (valid_Ma=1, inst opcode 0110011, alu_out=0x0000_0011) -> next cycle valid_Wb=1, alu_out_Wb=0x11, mem_data_Wb=0, dmem_req never high.
- SB with addr=0x1003, rs2=0xAABBCCDD, ack after 3 WAIT cycles:
  - dmem_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD, we=1.
  - stall_Ma high for 3 cycles; valid_Wb 1 cycle after ack.
- LB from addr=0x2002 with rdata=0x0080_0000 -> mem_data_Wb=0xFFFFFF80. LBU, same stimulus -> 0x00000080. LHU from addr=0x2002 with rdata=0x8001_0000 -> 0x00008001.
- Ack in the same cycle dmem_req first rises -> exactly one WAIT cycle; back-to-back loads issue two distinct requests with no lost instruction.
- rst_n pulsed low during WAIT, then ack=1 two cycles after release -> dmem_req=0 immediately, all outputs 0, late ack produces no valid_Wb.
- MA_MISALIGN_TRAP_EN defined, LW addr=0x3001 -> no dmem_req; next cycle valid_Wb=1, exc_Wb=1. Macro undefined, same stimulus -> request to 0x3000, exc_Wb=0.
